i2c_master_arbiter: RTL and testbench

- Shares one i2c_master between NUM_REQ requesters.
- Latches the winning request's address/data bytes and drives the master's address_in/data_in/start_send.
- Holds off new launches for a fixed transfer window, then reports completion to the owner.
- Sits between client blocks and i2c_master, in the same clk domain.

---
 rtl/i2c_arb_pkg.sv | 26 ++
 rtl/i2c_arb_picker.sv | 49 ++++
 rtl/i2c_master_arbiter.sv | 149 ++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the i2c_master arbiter.
//   - state_t / STATE_W : arbiter FSM encoding (IDLE, SETUP, START, WAIT)
//   - BYTE_W            : width of the address and data bytes handed to i2c_master
//   - clog2()           : width of the transfer-window down-counter
package i2c_arb_pkg;

    localparam int STATE_W = 2;
    localparam int BYTE_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Bits needed to hold values 0..n-1. Never returns less than 1, so a
    // one-cycle window still gets a real counter.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/i2c_arb_picker.sv
// Combinational rotating priority encoder.
// Searches req starting at index ptr and wrapping, and returns the first
// requester found.
// Ports:
//   req    in  NUM_REQ  request levels
//   ptr    in  ID_W     index that has highest priority this round
//   winner out ID_W     selected requester (0 when none)
//   valid  out 1        at least one request present
// Build option: I2C_ARB_FIXED_PRIO_EN ignores ptr, so the lowest index wins.
module i2c_arb_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    logic [ID_W-1:0] base;

`ifdef I2C_ARB_FIXED_PRIO_EN
    assign base = ptr & ID_W'(0);
`else
    assign base = ptr;
`endif

    always_comb begin
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        int                   sum;
        winner = '0;
        valid  = 1'b0;
        sum    = 0;
        // rot[j] is requester (base+j) mod NUM_REQ; scan from the top so the
        // smallest offset from base is the one that sticks.
        dbl = {req, req} >> base;
        rot = dbl[NUM_REQ-1:0];
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                sum = int'(base) + j;
                if (sum >= NUM_REQ) sum = sum - NUM_REQ;
                winner = ID_W'(sum);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters in the same clock domain.
// A winner's address/data bytes are latched and presented to the master,
// start_send is pulsed once, and the owner gets a done pulse after a fixed
// window of XFER_CYCLES clocks measured from that pulse.
// Ports:
//   clk, reset (async, active-low)
//   req/req_addr/req_data  in   per-requester level and byte slices [8i+7:8i]
//   ack, done              out  one-cycle per-requester pulses
//   busy                   out  FSM not in IDLE
//   grant_id               out  current/last owner
//   address_out, data_out  out  to i2c_master address_in/data_in
//   start_send             out  to i2c_master start_send
// Build option: I2C_ARB_FIXED_PRIO_EN selects fixed priority (lowest index)
// instead of round-robin; the round-robin pointer is then not built.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int XFER_CYCLES = 200,
    parameter int ID_W        = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [BYTE_W*NUM_REQ-1:0] req_addr,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic [BYTE_W-1:0]         address_out,
    output logic [BYTE_W-1:0]         data_out,
    output logic                      start_send
);

    localparam int CNT_W = clog2(XFER_CYCLES);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 start_q, start_d;
    logic [ID_W-1:0]      grant_q, grant_d;
    logic [BYTE_W-1:0]    addr_q, addr_d;
    logic [BYTE_W-1:0]    data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      win_id;
    logic                 win_vld;

`ifdef I2C_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [ID_W-1:0] rr_q, rr_d;
    assign ptr = rr_q;
`endif

    i2c_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (win_id),
        .valid  (win_vld)
    );

    // All outputs are registered: the pulse computed while in a state shows
    // up in the following cycle, which gives ack -> start_send of 2 cycles
    // and start_send -> done of exactly XFER_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        done_d  = '0;
        start_d = 1'b0;
        grant_d = grant_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifndef I2C_ARB_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    ack_d   = NUM_REQ'(1) << win_id;
                    grant_d = win_id;
                    addr_d  = req_addr[BYTE_W*win_id +: BYTE_W];
                    data_d  = req_data[BYTE_W*win_id +: BYTE_W];
`ifndef I2C_ARB_FIXED_PRIO_EN
                    rr_d    = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
`endif
                    state_d = SETUP;
                end
            end
            SETUP: state_d = START;
            START: begin
                start_d = 1'b1;
                cnt_d   = CNT_W'(XFER_CYCLES - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    done_d  = NUM_REQ'(1) << grant_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ack_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            grant_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifndef I2C_ARB_FIXED_PRIO_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            start_q <= start_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifndef I2C_ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
    assign address_out = addr_q;
    assign data_out    = data_q;
    assign start_send  = start_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
module tb_i2c_master_arbiter;

    localparam int NUM_REQ = 4;
    localparam int XFER    = 200;
    localparam int ID_W    = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_REQ-1:0]     req = '0;
    logic [8*NUM_REQ-1:0]   req_addr = '0;
    logic [8*NUM_REQ-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]     ack;
    logic [NUM_REQ-1:0]     done;
    logic                   busy;
    logic [ID_W-1:0]        grant_id;
    logic [7:0]             address_out;
    logic [7:0]             data_out;
    logic                   start_send;

    int n_checks = 0;
    int n_errors = 0;

    i2c_master_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .XFER_CYCLES (XFER),
        .ID_W        (ID_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .busy        (busy),
        .grant_id    (grant_id),
        .address_out (address_out),
        .data_out    (data_out),
        .start_send  (start_send)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 slot;
        logic [7:0]         addr;
        logic [7:0]         data;
        logic [NUM_REQ-1:0] exp_ack;
        logic [ID_W-1:0]    exp_grant;
        int                 exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req   = '0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    // Waits up to limit cycles for an ack pulse; returns its index or -1.
    task automatic wait_ack(input int limit, output int idx);
        idx = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (ack != '0) begin
                for (int b = 0; b < NUM_REQ; b++) if (ack[b]) idx = b;
                chk("ack_onehot", 32'($onehot(ack)), 1);
                break;
            end
        end
        chk("ack_seen", 32'(idx >= 0), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int extra;
        req_addr[8*v.slot +: 8] = v.addr;
        req_data[8*v.slot +: 8] = v.data;
        req[v.slot] = 1'b1;
        tick();
        chk("ack", ack, v.exp_ack);
        chk("grant_id", grant_id, v.exp_grant);
        chk("address_out", address_out, v.addr);
        chk("data_out", data_out, v.data);
        chk("busy_setup", busy, 1);
        req[v.slot] = 1'b0;
        tick();
        chk("start_early", start_send, 0);
        tick();
        chk("start_send", start_send, 1);
        chk("addr_at_start", address_out, v.addr);
        n = 0;
        extra = 0;
        while (done == '0 && n < XFER + 100) begin
            tick();
            n++;
            if (start_send) extra++;
        end
        chk("done_latency", n, v.exp_lat);
        chk("done_vec", done, v.exp_ack);
        chk("busy_after", busy, 0);
        chk("extra_start", extra, 0);
        chk("data_hold", data_out, v.data);
        tick();
        chk("done_single", done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout expired, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int n;
        int seen;
        int exp_c[5];
        int exp_f[4];

        vecs[0] = '{0, 8'hB5, 8'hA2, 4'b0001, 2'd0, XFER};
        vecs[1] = '{1, 8'h5A, 8'h11, 4'b0010, 2'd1, XFER};
        vecs[2] = '{2, 8'h3C, 8'hC3, 4'b0100, 2'd2, XFER};
        vecs[3] = '{3, 8'hFF, 8'h00, 4'b1000, 2'd3, XFER};
        vecs[4] = '{0, 8'h00, 8'hFF, 4'b0001, 2'd0, XFER};
`ifdef I2C_ARB_FIXED_PRIO_EN
        exp_c = '{0, 0, 1, 2, 3};
        exp_f = '{1, 1, 1, 1};
`else
        exp_c = '{0, 1, 2, 3, 0};
        exp_f = '{1, 3, 1, 3};
`endif

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_send, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_addr", address_out, 0);
        chk("rst_data", data_out, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Single-request vectors
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Contention: all four at once, req[0] re-raised at its done
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[8*i +: 8] = 8'h10 + 8'(i);
            req_data[8*i +: 8] = 8'hD0 + 8'(i);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(XFER + 100, got);
            chk("contention_order", got, exp_c[k]);
            if (got >= 0) begin
                chk("contention_data", data_out, 8'hD0 + 8'(got));
                req[got] = 1'b0;
            end
            if (k == 0) begin
                n = 0;
                while (done == '0 && n < XFER + 100) begin
                    tick();
                    n++;
                end
                chk("contention_done0", done, 4'b0001);
                req[0] = 1'b1;
            end
        end

        // Fairness: req[1] and req[3] held continuously
        do_reset();
        req[1] = 1'b1;
        req[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(XFER + 100, got);
            chk("fair_order", got, exp_f[k]);
        end
        do_reset();

        // Request raised during requester 0's WAIT
        req_addr[7:0] = 8'hB5;
        req_data[7:0] = 8'hA2;
        req[0] = 1'b1;
        tick();
        chk("mid_ack0", ack, 4'b0001);
        req[0] = 1'b0;
        repeat (5) tick();
        req_addr[23:16] = 8'h44;
        req_data[23:16] = 8'h3C;
        req[2] = 1'b1;
        seen = 0;
        n = 0;
        while (done == '0 && n < XFER + 100) begin
            tick();
            n++;
            if (ack != '0) seen = 1;
        end
        chk("mid_no_early_ack", seen, 0);
        chk("mid_done0", done, 4'b0001);
        tick();
        chk("mid_ack2", ack, 4'b0100);
        chk("mid_data", data_out, 8'h3C);
        chk("mid_addr", address_out, 8'h44);
        req[2] = 1'b0;
        do_reset();

        // Reset asserted with the window counter at 100
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        tick();
        tick();
        chk("rstw_start", start_send, 1);
        repeat (99) tick();
        reset = 1'b0;
        #1;
        chk("rstw_start_off", start_send, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_addr", address_out, 0);
        chk("rstw_data", data_out, 0);
        chk("rstw_grant", grant_id, 0);
        repeat (2) tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < XFER + 50; i++) begin
            tick();
            if (done != '0) seen = 1;
        end
        chk("rstw_no_done", seen, 0);
        run_vec('{1, 8'h21, 8'h43, 4'b0010, 2'd1, XFER});

        // req[3] pulsed for one cycle while busy
        req[0] = 1'b1;
        tick();
        chk("wd_ack0", ack, 4'b0001);
        req[0] = 1'b0;
        repeat (10) tick();
        req[3] = 1'b1;
        tick();
        req[3] = 1'b0;
        seen = 0;
        got = 0;
        for (int i = 0; i < XFER + 100; i++) begin
            tick();
            if (ack[3] || done[3]) seen = 1;
            if (done[0]) got = 1;
        end
        chk("wd_no_req3", seen, 0);
        chk("wd_done0", got, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
